// File: rtl/seg_pkg.sv
// seg_pkg: glyph codes and 7-segment patterns (a..g at bits 6..0, active-low)
package seg_pkg;
  localparam logic [3:0] GLYPH_P     = 4'hA;
  localparam logic [3:0] GLYPH_F     = 4'hB;
  localparam logic [3:0] GLYPH_S     = 4'hC;
  localparam logic [3:0] GLYPH_DASH  = 4'hD;
  localparam logic [3:0] GLYPH_BLANK = 4'hE;
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [15:0][6:0] SEG_ROM = {
    SEG_BLANK, SEG_BLANK, 7'b1111110, 7'b0100100,
    7'b0111000, 7'b0011000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational 4-bit glyph code to active-low segment pattern
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_ROM[i_code];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode scanner with frame-synchronous double buffer,
// per-digit blink and dead time; define SEG_SCAN_DP_EN to add decimal-point support
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   blink_in,
`ifdef SEG_SCAN_DP_EN
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  dp_n,
`endif
  output logic                  pending,
  output logic                  frame_tick,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an_n
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [4*N_DIGITS-1:0] ALL_BLANK = {N_DIGITS{GLYPH_BLANK}};

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [FW-1:0]         r_frm;
  logic                  r_phase;
  logic [4*N_DIGITS-1:0] r_sh_dig, r_act_dig;
  logic [N_DIGITS-1:0]   r_sh_blk, r_act_blk;
  logic                  r_pending, r_tick;
  logic [6:0]            r_seg;
  logic [N_DIGITS-1:0]   r_an_n;
  logic                  w_tc, w_wrap, w_frm_end, w_dead, w_blank, w_commit;
  logic [3:0]            w_code;
  logic [6:0]            w_rom;

  assign w_tc      = r_pre == PW'(SCAN_DIV - 1);
  assign w_wrap    = w_tc && (r_idx == IW'(N_DIGITS - 1));
  assign w_frm_end = r_frm == FW'(BLINK_FRAMES - 1);
  assign w_dead    = r_pre == '0;
  assign w_commit  = w_wrap && r_pending;
  assign w_code    = r_act_dig[{r_idx, 2'b00} +: 4];
  assign w_blank   = r_phase && r_act_blk[r_idx];

  seg_glyph_rom u_rom (.i_code(w_code), .o_seg(w_rom));

  // slot prescaler, digit index, frame counter and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else begin
      r_pre <= w_tc ? '0 : r_pre + PW'(1);
      if (w_tc) r_idx <= w_wrap ? '0 : r_idx + IW'(1);
      if (w_wrap) begin
        r_frm <= w_frm_end ? '0 : r_frm + FW'(1);
        if (w_frm_end) r_phase <= ~r_phase;
      end
    end
  end

  // shadow captures every load; active takes the pre-edge shadow only at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_dig  <= ALL_BLANK;
      r_sh_blk  <= '0;
      r_act_dig <= ALL_BLANK;
      r_act_blk <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load) begin
        r_sh_dig <= digits_in;
        r_sh_blk <= blink_in;
      end
      if (w_commit) begin
        r_act_dig <= r_sh_dig;
        r_act_blk <= r_sh_blk;
      end
      r_pending <= load || (r_pending && !w_wrap);
    end
  end

  // registered pin drivers: anodes dark in the first cycle of each slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg  <= SEG_BLANK;
      r_an_n <= '1;
      r_tick <= 1'b0;
    end else begin
      r_seg  <= w_blank ? SEG_BLANK : w_rom;
      r_an_n <= w_dead ? '1 : ~(N_DIGITS'(1) << r_idx);
      r_tick <= w_wrap;
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [N_DIGITS-1:0] r_sh_dp, r_act_dp;
  logic                r_dp_n;

  // decimal points follow the same double buffer and blanking as the glyphs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_dp  <= '0;
      r_act_dp <= '0;
      r_dp_n   <= 1'b1;
    end else begin
      if (load) r_sh_dp <= dp_in;
      if (w_commit) r_act_dp <= r_sh_dp;
      r_dp_n <= (w_dead || w_blank) ? 1'b1 : ~r_act_dp[r_idx];
    end
  end

  assign dp_n = r_dp_n;
`endif

  assign pending    = r_pending;
  assign frame_tick = r_tick;
  assign seg        = r_seg;
  assign an_n       = r_an_n;
endmodule
